// File: rtl/stream_cipher_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_cipher_if
//  Description : Pad-frame bus bundle for the byte-serial stream cipher.
//                ena    - clock enable
//                ui_in  - data byte (key byte or plaintext/ciphertext)
//                uio_in - [1:0] command, [2] status-pin disable
//                uo_out - registered cipher byte
//                uio_out- [7] valid, [6:3] byte count, [2:0] zero
//                uio_oe - output enables for the bidir pads
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_cipher_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface
`default_nettype wire

// File: rtl/stream_cipher.sv
`default_nettype none
// ============================================================================
//  Module      : stream_cipher
//  Description : Byte-serial symmetric stream cipher. A 32-bit key is shifted
//                in a byte at a time, RESEED copies it into a 32-bit Galois
//                LFSR, and each CRYPT XORs one input byte with one keystream
//                byte while advancing the LFSR eight steps.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - stream_cipher_if.slave (ena, ui_in, uio_in,
//                       uo_out, uio_out, uio_oe)
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_cipher #(
    parameter logic [31:0] SEED = 32'h0000_0001,
    parameter logic [31:0] POLY = 32'h8020_0003
) (
    input  logic           clk,
    input  logic           rst,
    stream_cipher_if.slave bus
);

    localparam logic [1:0] c_cmd_idle   = 2'b00;
    localparam logic [1:0] c_cmd_load   = 2'b01;
    localparam logic [1:0] c_cmd_crypt  = 2'b10;
    localparam logic [1:0] c_cmd_reseed = 2'b11;

    logic [31:0] r_key;
    logic [31:0] r_state;
    logic [7:0]  r_uo;
    logic        r_valid;
    logic [3:0]  r_count;

    logic [1:0]  w_cmd;
    logic [7:0]  w_ks;
    logic [31:0] w_state_next;
    logic [31:0] w_reseed_val;

    // Eight Galois steps unrolled into one combinational cone so a CRYPT
    // consumes exactly one keystream byte per cycle.
    function automatic logic [31:0] lfsr_adv8(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
        end
        return v;
    endfunction

    assign w_cmd        = bus.uio_in[1:0];
    // Keystream taken from the pre-advance state.
    assign w_ks         = r_state[7:0] ^ r_state[23:16];
    assign w_state_next = lfsr_adv8(r_state);
    // A zero key would lock the LFSR at zero, so it falls back to SEED.
    assign w_reseed_val = (r_key == 32'h0) ? SEED : r_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key   <= 32'h0;
            r_state <= SEED;
            r_uo    <= 8'h00;
            r_valid <= 1'b0;
            r_count <= 4'h0;
        end else if (bus.ena) begin
            case (w_cmd)
                c_cmd_idle: begin
                    r_valid <= 1'b0;
                end
                c_cmd_load: begin
                    r_key   <= {r_key[23:0], bus.ui_in};
                    r_valid <= 1'b0;
                end
                c_cmd_crypt: begin
                    r_uo    <= bus.ui_in ^ w_ks;
                    r_state <= w_state_next;
                    r_valid <= 1'b1;
                    r_count <= r_count + 4'h1;
                end
                c_cmd_reseed: begin
                    r_state <= w_reseed_val;
                    r_count <= 4'h0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.uo_out  = r_uo;
    // Status value is presented regardless of the pad enables; all fields
    // are registers cleared by reset, so the bus reads zero during reset.
    assign bus.uio_out = {r_valid, r_count, 3'b000};
    // Pads [2:0] are inputs; status pins [7:3] drive only when not disabled.
    assign bus.uio_oe  = {{5{~bus.uio_in[2]}}, 3'b000};

    // Upper uio_in bits have no input function.
    logic w_unused_uio_in;
    assign w_unused_uio_in = &{1'b0, bus.uio_in[7:3]};

endmodule
`default_nettype wire

// File: tb/tb_stream_cipher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_cipher
//  Description : Self-checking bench for stream_cipher: directed vector table,
//                hand-written wrap / async-reset sequences, and randomized
//                traffic against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_cipher;

    localparam logic [31:0] c_seed = 32'h0000_0001;
    localparam logic [31:0] c_poly = 32'h8020_0003;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    stream_cipher_if bus_if();

    stream_cipher #(.SEED(c_seed), .POLY(c_poly)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ena;
        logic [1:0] cmd;
        logic [7:0] din;
        logic       dis;
        logic [7:0] exp_uo;
        logic       exp_valid;
        logic [3:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    // Reference model: cipher state as plain numbers.
    longint unsigned m_key;
    longint unsigned m_s;
    int              m_uo;
    int              m_valid;
    int              m_count;

    function automatic longint unsigned ref_step(input longint unsigned s);
        if (s % 2 == 1) return (s / 2) ^ 64'(c_poly);
        return s / 2;
    endfunction

    task automatic model_reset();
        m_key = 0; m_s = c_seed; m_uo = 0; m_valid = 0; m_count = 0;
    endtask

    task automatic model_apply(input logic en, input logic [1:0] cmd, input logic [7:0] din);
        int ks;
        if (!en) return;
        case (cmd)
            2'd0: m_valid = 0;
            2'd1: begin
                m_key   = ((m_key * 256) + din) % 64'h1_0000_0000;
                m_valid = 0;
            end
            2'd2: begin
                ks      = int'((m_s % 256) ^ ((m_s / 65536) % 256));
                m_uo    = din ^ ks;
                for (int k = 0; k < 8; k++) m_s = ref_step(m_s);
                m_valid = 1;
                m_count = (m_count + 1) % 16;
            end
            default: begin
                m_s     = (m_key == 0) ? c_seed : m_key;
                m_count = 0;
                m_valid = 0;
            end
        endcase
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, let the rising edge
    // sample them, then advance the model; caller checks after return.
    task automatic cycle(input logic en, input logic [1:0] cmd, input logic [7:0] din, input logic dis);
        @(negedge clk);
        bus_if.ena    = en;
        bus_if.ui_in  = din;
        bus_if.uio_in = {5'($urandom), dis, cmd};
        @(posedge clk);
        #1;
        model_apply(en, cmd, din);
    endtask

    task automatic check_model(input string tag);
        check8({tag, "_uo"},  bus_if.uo_out,  8'(m_uo));
        check8({tag, "_uio"}, bus_if.uio_out, {1'(m_valid), 4'(m_count), 3'b000});
        check8({tag, "_oe"},  bus_if.uio_oe,  bus_if.uio_in[2] ? 8'h00 : 8'hF8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        model_reset();

        // Directed table: after key 00000001 the state is 1, then 0xDB36C002.
        vecs.push_back('{1'b1, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 2'd1, 8'h00, 1'b1, 8'h00, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 2'd1, 8'h01, 1'b0, 8'h00, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 2'd2, 8'h00, 1'b0, 8'h01, 1'b1, 4'd1});
        vecs.push_back('{1'b1, 2'd2, 8'hAA, 1'b0, 8'h9E, 1'b1, 4'd2});
        vecs.push_back('{1'b1, 2'd3, 8'h00, 1'b1, 8'h9E, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 2'd2, 8'h01, 1'b0, 8'h00, 1'b1, 4'd1});
        vecs.push_back('{1'b1, 2'd2, 8'h9E, 1'b0, 8'hAA, 1'b1, 4'd2});
        vecs.push_back('{1'b0, 2'd2, 8'h55, 1'b0, 8'hAA, 1'b1, 4'd2});
        vecs.push_back('{1'b1, 2'd0, 8'h55, 1'b0, 8'hAA, 1'b0, 4'd2});
        vecs.push_back('{1'b1, 2'd1, 8'h00, 1'b0, 8'hAA, 1'b0, 4'd2});
        vecs.push_back('{1'b1, 2'd1, 8'h00, 1'b0, 8'hAA, 1'b0, 4'd2});
        vecs.push_back('{1'b1, 2'd1, 8'h00, 1'b0, 8'hAA, 1'b0, 4'd2});
        vecs.push_back('{1'b1, 2'd1, 8'h00, 1'b0, 8'hAA, 1'b0, 4'd2});
        vecs.push_back('{1'b1, 2'd3, 8'h00, 1'b0, 8'hAA, 1'b0, 4'd0});
        vecs.push_back('{1'b1, 2'd2, 8'h00, 1'b0, 8'h01, 1'b1, 4'd1});

        // Reset
        rst           = 1'b1;
        bus_if.ena    = 1'b0;
        bus_if.ui_in  = 8'h00;
        bus_if.uio_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check8("rst_uio_out", bus_if.uio_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check8("rst_uo",     bus_if.uo_out,  8'h00);
        check8("rst_uio",    bus_if.uio_out, 8'h00);
        check8("rst_oe_en",  bus_if.uio_oe,  8'hF8);
        bus_if.uio_in = 8'h04;
        #1;
        check8("rst_oe_dis", bus_if.uio_oe,  8'h00);

        foreach (vecs[i]) begin
            cycle(vecs[i].ena, vecs[i].cmd, vecs[i].din, vecs[i].dis);
            check8($sformatf("vec%0d_uo", i),  bus_if.uo_out, vecs[i].exp_uo);
            check8($sformatf("vec%0d_uio", i), bus_if.uio_out,
                   {vecs[i].exp_valid, vecs[i].exp_count, 3'b000});
            check8($sformatf("vec%0d_oe", i),  bus_if.uio_oe, vecs[i].dis ? 8'h00 : 8'hF8);
        end

        // Counter wrap: key is zero, so RESEED restarts from SEED.
        cycle(1'b1, 2'd3, 8'h00, 1'b0);
        for (int n = 1; n <= 16; n++) begin
            cycle(1'b1, 2'd2, 8'h00, 1'b0);
            if (n == 15) check8("wrap_cnt15", bus_if.uio_out, 8'hF8);
        end
        check8("wrap_cnt0", bus_if.uio_out, 8'h80);

        // Asynchronous reset mid-stream takes effect before any clock edge.
        cycle(1'b1, 2'd2, 8'h5A, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check8("async_uo",  bus_if.uo_out,  8'h00);
        check8("async_uio", bus_if.uio_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        // Key lost: reseed falls back to SEED, first keystream byte is 0x01.
        cycle(1'b1, 2'd3, 8'h00, 1'b0);
        cycle(1'b1, 2'd2, 8'h00, 1'b0);
        check8("post_rst_uo", bus_if.uo_out, 8'h01);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic       en;
            logic [1:0] cmd;
            en  = ($urandom_range(0, 7) != 0);
            cmd = 2'($urandom_range(0, 3));
            cycle(en, cmd, 8'($urandom), 1'($urandom));
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_cipher.md
Name:
stream_cipher

Overview:
- Byte-serial symmetric stream cipher in the standard 8-in / 8-out / 8-bidir pad-frame tile.
- A 32-bit key is shifted in one byte at a time. A reseed command copies the key into a 32-bit Galois LFSR.
- Each encrypt command XORs the input byte with one keystream byte and advances the LFSR 8 steps.
- Decryption is the identical operation from the same key/reseed point.

Parameters:
- SEED, 32'h0000_0001, LFSR state after reset; must be nonzero.
- POLY, 32'h8020_0003, Galois feedback mask (x^32+x^22+x^2+x+1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  clock enable; low = all state holds.
- ui_in  in  8  data byte (key byte or plaintext/ciphertext).
- uio_in  in  8  [1:0] command, [2] status-pin disable; [7:3] unused as inputs.
- uo_out  out  8  registered cipher output byte.
- uio_out  out  8  [7] valid pulse, [6:3] byte counter[3:0], [2:0] constant 0.
- uio_oe  out  8  output enables.

Behaviour:
- Reset (rst=1, async) clears or sets the following:
  - key=0, S=SEED, uo_out=0, valid=0, count=0.
  - uio_out=0 while reset is asserted.
- Commands are sampled on each rising clk when ena=1 and rst=0. cmd=uio_in[1:0]:
  - 00 IDLE: no state change; valid<=0.
  - 01 LOAD_KEY: key <= {key[23:0], ui_in}; valid<=0.
  - 10 CRYPT:
    - ks = S[7:0] ^ S[23:16], computed from the pre-advance state.
    - uo_out <= ui_in ^ ks.
    - S <= S advanced 8 LFSR steps; valid<=1; count<=count+1 (4-bit, wraps 15->0).
  - 11 RESEED: S <= (key==0) ? SEED : key; count<=0; valid<=0.
- LFSR step: lsb=S[0]; S=S>>1; if lsb, S=S^POLY. All 8 steps are combinational within the same cycle.
- The all-zero state is unreachable: SEED is nonzero, a zero key maps to SEED, and POLY keeps nonzero states nonzero.
- uo_out holds its last value in every non-CRYPT cycle. Latency is 1 clock from CRYPT sampling to uo_out/valid.
- valid is a 1-cycle pulse per CRYPT cycle; back-to-back CRYPT keeps valid high.
- ena=0: nothing changes, including valid (it holds).
- uio_oe = {5{~uio_in[2]}, 3'b000}, purely combinational. Bits [2:0] are always inputs. Status pins [7:3] are driven only when uio_in[2]=0.
- uio_out[7:3] = {valid, count[3:0]} whenever the pins are enabled; the value is independent of oe.
- Reset asserted mid-stream aborts immediately. The key is lost and must be reloaded.

Test Plan:
- Reset with rst=1, then release -> uo_out=0x00, uio_out=0x00; uio_oe=0xF8 with uio_in[2]=0, 0x00 with uio_in[2]=1.
- LOAD_KEY 00,00,00,01, then RESEED, then CRYPT ui_in=0x00 -> uo_out=0x01, valid=1, count=1.
- Continue with CRYPT ui_in=0xAA -> uo_out=0x9E (ks=0x34, from S=0xDB36C002), count=2.
- Decrypt: RESEED, then CRYPT 0x01, then CRYPT 0x9E -> uo_out 0x00 then 0xAA.
- ena=0 during CRYPT, or IDLE after CRYPT -> uo_out holds; valid 0 after IDLE; count unchanged.
- Zero key: RESEED with key=0, then CRYPT 0x00 -> uo_out=0x01 (SEED used). Also: 16 CRYPTs -> count wraps to 0.
